// File: rtl/timer_sched_pkg.sv
// Shared types and Avalon interval-timer register constants for timer_delay_scheduler.
package timer_sched_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ARB,
    WR_PL,
    WR_PH,
    WR_CTRL,
    WAIT_IRQ,
    WR_STOP,
    WR_CLR,
    DONE
  } state_t;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

  localparam logic [15:0] CTRL_ITO   = 16'h0001;
  localparam logic [15:0] CTRL_CONT  = 16'h0002;
  localparam logic [15:0] CTRL_START = 16'h0004;
  localparam logic [15:0] CTRL_STOP  = 16'h0008;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  int               pos;
  logic             found;
  logic [IDX_W-1:0] sel;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    sel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      sel = IDX_W'(pos);
      if (!found && req[sel]) begin
        found      = 1'b1;
        idx        = sel;
        grant[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_delay_scheduler.sv
// Shares one Avalon-MM interval timer among NUM_REQ one-shot delay requesters,
// programming it as a write-only master and returning a done pulse per delay.
module timer_delay_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] req_delay,
  input  logic [NUM_REQ-1:0]    cancel,
  output logic [NUM_REQ-1:0]    done,
  output logic                  cancelled,
  output logic                  busy,
  output logic [IDX_W-1:0]      grant_idx,
  output logic [2:0]            tmr_address,
  output logic                  tmr_chipselect,
  output logic                  tmr_write_n,
  output logic [15:0]           tmr_writedata,
  input  logic                  tmr_irq
);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   arb_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic [31:0]        arb_delay;
  logic [31:0]        period;
  logic               cancel_flag;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign arb_delay = req_delay[{arb_idx, 5'd0} +: 32];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_idx   <= '0;
      cancel_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ARB && arb_grant != '0) begin
        grant_idx <= arb_idx;
        ptr       <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
      end
      if (state == WR_STOP) cancel_flag <= 1'b1;
      else if (state == DONE) cancel_flag <= 1'b0;
    end
  end

  // The timer counts period..0, so D cycles need period D-1.
  always_ff @(posedge clk) begin
    if (state == ARB) period <= arb_delay - 32'd1;
  end

  always_comb begin
    state_nxt      = state;
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = '0;
    tmr_writedata  = '0;
    done           = '0;
    cancelled      = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        if (req != '0) state_nxt = ARB;
      end
      ARB: begin
        if (arb_grant == '0)     state_nxt = IDLE;
        else if (arb_delay == 0) state_nxt = DONE;
        else                     state_nxt = WR_PL;
      end
      WR_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_PERIOD_L;
        tmr_writedata  = period[15:0];
        state_nxt      = WR_PH;
      end
      WR_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_PERIOD_H;
        tmr_writedata  = period[31:16];
        state_nxt      = WR_CTRL;
      end
      WR_CTRL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_CONTROL;
        tmr_writedata  = CTRL_START | CTRL_ITO;
        state_nxt      = WAIT_IRQ;
      end
      WAIT_IRQ: begin
        // An irq arriving with a cancel still counts as an elapsed delay.
        if (tmr_irq)                state_nxt = WR_CLR;
        else if (cancel[grant_idx]) state_nxt = WR_STOP;
      end
      WR_STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_CONTROL;
        tmr_writedata  = CTRL_STOP;
        state_nxt      = WR_CLR;
      end
      WR_CLR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = ADDR_STATUS;
        tmr_writedata  = '0;
        state_nxt      = DONE;
      end
      DONE: begin
        done[grant_idx] = 1'b1;
        cancelled       = cancel_flag;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_timer_delay_scheduler.sv
// Bench for timer_delay_scheduler: behavioural interval timer, vector table,
// hand-written corner sequences and a randomized round-robin reference model.
module tb_timer_delay_scheduler;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ-1:0]    cancel = '0;
  logic [NUM_REQ*32-1:0] req_delay = '0;
  logic [NUM_REQ-1:0]    done;
  logic                  cancelled, busy, tmr_chipselect, tmr_write_n, tmr_irq;
  logic [IDX_W-1:0]      grant_idx;
  logic [2:0]            tmr_address;
  logic [15:0]           tmr_writedata;
  logic                  irq_force = 1'b0;

  always #5 clk = ~clk;

  timer_delay_scheduler #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_delay      (req_delay),
    .cancel         (cancel),
    .done           (done),
    .cancelled      (cancelled),
    .busy           (busy),
    .grant_idx      (grant_idx),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq)
  );

  // Behavioural interval timer: irq after period+1 running cycles, one-shot.
  logic [15:0] tm_pl = '0, tm_ph = '0;
  logic [31:0] tm_cnt = '0;
  logic        tm_run = 1'b0, tm_to = 1'b0, tm_ito = 1'b0;

  always @(posedge clk) begin
    if (tmr_chipselect && !tmr_write_n) begin
      case (tmr_address)
        3'd0: tm_to <= 1'b0;
        3'd1: begin
          tm_ito <= tmr_writedata[0];
          if (tmr_writedata[3]) tm_run <= 1'b0;
          else if (tmr_writedata[2]) begin
            tm_run <= 1'b1;
            tm_cnt <= {tm_ph, tm_pl};
          end
        end
        3'd2: begin tm_pl <= tmr_writedata; tm_run <= 1'b0; end
        3'd3: begin tm_ph <= tmr_writedata; tm_run <= 1'b0; end
        default: ;
      endcase
    end else if (tm_run) begin
      if (tm_cnt == 0) begin
        tm_to  <= 1'b1;
        tm_run <= 1'b0;
      end else begin
        tm_cnt <= tm_cnt - 1;
      end
    end
  end

  assign tmr_irq = (tm_to & tm_ito) | irq_force;

  typedef struct {int cyc; int a; int d;} wr_t;
  typedef struct {int cyc; int vec; int can;} dn_t;
  typedef struct {int idx; logic [31:0] d; int pl; int ph; logic [3:0] noise;} vec_t;

  wr_t  wq[$];
  dn_t  dq[$];
  vec_t tv[5];
  int   cyc = 0, n_cmp = 0, n_fail = 0, cs_seen = 0, irq_seen = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock; observe #1 after the edge; requesters drop req on their done.
  task automatic step();
    wr_t w;
    dn_t d;
    @(posedge clk);
    #1;
    cyc++;
    if (tmr_chipselect) cs_seen++;
    if (tmr_irq) irq_seen++;
    if (tmr_chipselect && !tmr_write_n) begin
      w.cyc = cyc; w.a = int'(tmr_address); w.d = int'(tmr_writedata);
      wq.push_back(w);
    end
    if (done != '0) begin
      d.cyc = cyc; d.vec = int'(done); d.can = int'(cancelled);
      dq.push_back(d);
      req = req & ~done;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    wq.delete();
    dq.delete();
    cs_seen  = 0;
    irq_seen = 0;
  endtask

  task automatic set_dly(input int i, input logic [31:0] d);
    req_delay[32*i +: 32] = d;
  endtask

  task automatic wait_dones(input int n, input int budget, input string nm);
    int k = 0;
    while (dq.size() < n && k < budget) begin step(); k++; end
    chk({nm, " done count"}, dq.size(), n);
  endtask

  task automatic wait_writes(input int n, input int budget, input string nm);
    int k = 0;
    while (wq.size() < n && k < budget) begin step(); k++; end
    chk({nm, " write count"}, wq.size(), n);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " done"}, done, 0);
    chk({nm, " chipselect"}, tmr_chipselect, 0);
    chk({nm, " write_n"}, tmr_write_n, 1);
    chk({nm, " grant_idx"}, grant_idx, 0);
    chk({nm, " cancelled"}, cancelled, 0);
    chk({nm, " address"}, tmr_address, 0);
    chk({nm, " writedata"}, tmr_writedata, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ptr_m, t, nz, k;
    logic [3:0]  m, pend;
    int          dly[NUM_REQ];
    int          exp_idx[$];
    int          exp_cyc[$];
    logic [31:0] dm1;

    tv[0] = '{1, 32'd100, 99, 0, 4'b0101};
    tv[1] = '{2, 32'd1,   0,  0, 4'b0000};
    tv[2] = '{0, 32'd3,   2,  0, 4'b1110};
    tv[3] = '{3, 32'd37,  36, 0, 4'b0000};
    tv[4] = '{1, 32'd2,   1,  0, 4'b1000};

    reset_n = 1'b0;
    idle(3);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    idle(2);

    for (int i = 0; i < 5; i++) begin
      clear_logs();
      set_dly(tv[i].idx, tv[i].d);
      cancel = tv[i].noise;
      req[tv[i].idx] = 1'b1;
      wait_dones(1, int'(tv[i].d) + 30, $sformatf("vec%0d", i));
      cancel = '0;
      chk($sformatf("vec%0d writes", i), wq.size(), 4);
      if (wq.size() == 4) begin
        chk($sformatf("vec%0d pl addr", i), wq[0].a, 2);
        chk($sformatf("vec%0d pl data", i), wq[0].d, tv[i].pl);
        chk($sformatf("vec%0d ph addr", i), wq[1].a, 3);
        chk($sformatf("vec%0d ph data", i), wq[1].d, tv[i].ph);
        chk($sformatf("vec%0d ctrl addr", i), wq[2].a, 1);
        chk($sformatf("vec%0d ctrl data", i), wq[2].d, 5);
        chk($sformatf("vec%0d clr addr", i), wq[3].a, 0);
        chk($sformatf("vec%0d clr data", i), wq[3].d, 0);
      end
      if (dq.size() == 1 && wq.size() > 0) begin
        chk($sformatf("vec%0d done vec", i), dq[0].vec, 1 << tv[i].idx);
        chk($sformatf("vec%0d cancelled", i), dq[0].can, 0);
        chk($sformatf("vec%0d latency", i), dq[0].cyc - wq[0].cyc, int'(tv[i].d) + 5);
      end
      idle(3);
    end

    // Zero delay: no timer traffic, cancel outside WAIT_IRQ ignored.
    clear_logs();
    set_dly(3, 32'd0);
    cancel = 4'b1000;
    req[3] = 1'b1;
    wait_dones(1, 20, "zero");
    cancel = '0;
    idle(3);
    if (dq.size() == 1) begin
      chk("zero done vec", dq[0].vec, 8);
      chk("zero cancelled", dq[0].can, 0);
    end
    chk("zero chipselect cycles", cs_seen, 0);

    // Round robin from pointer 0, then re-raise 0 and 2.
    clear_logs();
    for (int i = 0; i < NUM_REQ; i++) set_dly(i, 32'd10);
    req = 4'b1111;
    wait_dones(4, 200, "rr");
    if (dq.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("rr order %0d", i), dq[i].vec, 1 << i);
    if (wq.size() >= 5 && dq.size() >= 1) chk("rr gap", wq[4].cyc - dq[0].cyc, 3);
    idle(2);
    clear_logs();
    req = 4'b0101;
    wait_dones(2, 100, "rr2");
    if (dq.size() == 2) begin
      chk("rr2 first", dq[0].vec, 1);
      chk("rr2 second", dq[1].vec, 4);
    end
    idle(2);

    // Cancel in WAIT_IRQ cycle 50.
    clear_logs();
    set_dly(0, 32'd1000);
    req[0] = 1'b1;
    wait_writes(3, 20, "cancel");
    idle(51);
    cancel[0] = 1'b1;
    step();
    cancel = '0;
    wait_dones(1, 20, "cancel");
    chk("cancel writes", wq.size(), 5);
    if (wq.size() == 5) begin
      chk("cancel stop addr", wq[3].a, 1);
      chk("cancel stop data", wq[3].d, 8);
      chk("cancel clr addr", wq[4].a, 0);
    end
    if (dq.size() == 1) begin
      chk("cancel done vec", dq[0].vec, 1);
      chk("cancel cancelled", dq[0].can, 1);
    end
    irq_seen = 0;
    idle(1100);
    chk("cancel irq after", irq_seen, 0);

    // irq and cancel together; large delay split.
    clear_logs();
    set_dly(2, 32'h0002_0001);
    req[2] = 1'b1;
    wait_writes(3, 20, "race");
    if (wq.size() >= 2) begin
      chk("race pl data", wq[0].d, 0);
      chk("race ph data", wq[1].d, 2);
    end
    idle(5);
    irq_force = 1'b1;
    cancel[2] = 1'b1;
    step();
    irq_force = 1'b0;
    cancel    = '0;
    wait_dones(1, 20, "race");
    chk("race writes", wq.size(), 4);
    if (wq.size() == 4) chk("race clr addr", wq[3].a, 0);
    if (dq.size() == 1) begin
      chk("race done vec", dq[0].vec, 4);
      chk("race cancelled", dq[0].can, 0);
    end
    idle(2);

    // Reset while waiting for irq.
    clear_logs();
    set_dly(1, 32'd500);
    req[1] = 1'b1;
    wait_writes(3, 20, "rst");
    idle(20);
    reset_n = 1'b0;
    req     = '0;
    step();
    chk_reset_outputs("midreset");
    reset_n = 1'b1;
    idle(10);
    chk("midreset no done", dq.size(), 0);
    clear_logs();
    set_dly(2, 32'd20);
    req[2] = 1'b1;
    wait_dones(1, 60, "postreset");
    chk("postreset writes", wq.size(), 4);
    if (dq.size() == 1 && wq.size() > 0) begin
      chk("postreset done vec", dq[0].vec, 4);
      chk("postreset latency", dq[0].cyc - wq[0].cyc, 25);
      chk("postreset cancelled", dq[0].can, 0);
    end
    idle(2);

    // Randomized rounds against an arithmetic round-robin/latency model.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    idle(2);
    ptr_m = 0;
    for (int r = 0; r < 30; r++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < NUM_REQ; i++) begin
        dly[i] = int'($urandom_range(0, 15));
        set_dly(i, 32'(dly[i]));
      end
      exp_idx.delete();
      exp_cyc.delete();
      pend = m;
      t    = cyc;
      nz   = 0;
      while (pend != '0) begin
        k = -1;
        for (int j = 0; j < NUM_REQ; j++)
          if (k < 0 && pend[(ptr_m + j) % NUM_REQ]) k = (ptr_m + j) % NUM_REQ;
        pend[k] = 1'b0;
        ptr_m   = (k + 1) % NUM_REQ;
        if (exp_idx.size() == 0) t = t + ((dly[k] > 0) ? dly[k] + 7 : 2);
        else                     t = t + ((dly[k] > 0) ? dly[k] + 8 : 3);
        if (dly[k] > 0) nz++;
        exp_idx.push_back(k);
        exp_cyc.push_back(t);
      end
      clear_logs();
      req = m;
      wait_dones($countones(m), 200, $sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d writes", r), wq.size(), 4 * nz);
      for (int j = 0; j < dq.size() && j < exp_idx.size(); j++) begin
        chk($sformatf("rnd%0d.%0d vec", r, j), dq[j].vec, 1 << exp_idx[j]);
        chk($sformatf("rnd%0d.%0d cyc", r, j), dq[j].cyc, exp_cyc[j]);
        chk($sformatf("rnd%0d.%0d cancelled", r, j), dq[j].can, 0);
      end
      if (wq.size() > 0) begin
        k   = -1;
        for (int j = 0; j < exp_idx.size(); j++)
          if (k < 0 && dly[exp_idx[j]] > 0) k = exp_idx[j];
        dm1 = 32'(dly[k]) - 32'd1;
        chk($sformatf("rnd%0d pl data", r), wq[0].d, int'(dm1[15:0]));
      end
      req = '0;
      idle(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
